// File: rtl/axil_inputoutput_pkg.sv
// Shared types and helpers for the axil_inputoutput_regs register block.
//   resp_t          : AXI response codes used by the block (OKAY / SLVERR)
//   w_state_t       : write channel FSM states
//   r_state_t       : read channel FSM states
//   irq_status_idx  : word index of IRQ_STATUS for a given NUM_OUT/NUM_IN
//   irq_mask_idx    : word index of IRQ_MASK for a given NUM_OUT/NUM_IN
package axil_inputoutput_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Interrupt registers sit directly after the input registers.
  function automatic int irq_status_idx(input int num_out, input int num_in);
    return num_out + num_in;
  endfunction

  function automatic int irq_mask_idx(input int num_out, input int num_in);
    return num_out + num_in + 1;
  endfunction

endpackage

// File: rtl/axil_io_sync.sv
// Two-flop synchroniser for one asynchronous input word, plus a
// previous-value register so the caller can detect changes of the
// synchronised value.
//   clk   : clock
//   rst_n : synchronous active-low reset, clears all stages
//   d     : asynchronous input word
//   q     : synchronised word (second flop)
//   chg   : high while q differs from its value one cycle earlier
module axil_io_sync #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         chg
);

  logic [W-1:0] s1, s2, prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= d;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign q   = s2;
  assign chg = (s2 != prev);

endmodule

// File: rtl/axil_inputoutput_regs.sv
// AXI4-Lite slave register block.
//   Word map (index = addr[ADDR_W-1:2]):
//     0 .. NUM_OUT-1              output registers (RW), drive gpio_out
//     NUM_OUT .. NUM_OUT+NUM_IN-1 synchronised gpio_in words (RO)
//     next                        IRQ_STATUS (W1C)  } only with
//     next                        IRQ_MASK   (RW)   } AXIL_INPUTOUTPUT_IRQ_EN
//   Anything else answers SLVERR (reads return 0).
// Ports:
//   ACLK / ARESETN            clock, synchronous active-low reset
//   S_AXI_AW* / W* / B*       write address, data, response channels
//   S_AXI_AR* / R*            read address and data channels
//   gpio_out                  output registers, register k at slice k
//   gpio_in                   asynchronous inputs, word j at slice j
//   irq                       level interrupt (AXIL_INPUTOUTPUT_IRQ_EN only)
// Optional feature macro: AXIL_INPUTOUTPUT_IRQ_EN (change-detect interrupts).
module axil_inputoutput_regs
  import axil_inputoutput_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                NUM_OUT     = 4,
  parameter int                NUM_IN      = 2,
  parameter int                ADDR_W      = 8,
  parameter logic [DATA_W-1:0] OUT_RST_VAL = '0
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [ADDR_W-1:0]         S_AXI_AWADDR,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [DATA_W-1:0]         S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]       S_AXI_WSTRB,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [ADDR_W-1:0]         S_AXI_ARADDR,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  output logic [DATA_W-1:0]         S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY,
  output logic [NUM_OUT*DATA_W-1:0] gpio_out,
`ifdef AXIL_INPUTOUTPUT_IRQ_EN
  output logic                      irq,
`endif
  input  logic [NUM_IN*DATA_W-1:0]  gpio_in
);

  localparam int STAT_IDX = irq_status_idx(NUM_OUT, NUM_IN);
  localparam int MASK_IDX = irq_mask_idx(NUM_OUT, NUM_IN);
  localparam int NB       = DATA_W / 8;

  // Elaboration-time parameter checks.
  generate
    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
      $error("axil_inputoutput_regs: DATA_W must be 32 or 64");
    end
    if (NUM_OUT < 1 || NUM_OUT > 16 || NUM_IN < 1 || NUM_IN > 16) begin : g_bad_count
      $error("axil_inputoutput_regs: NUM_OUT and NUM_IN must be 1..16");
    end
    if (STAT_IDX >= (1 << (ADDR_W - 2)) || MASK_IDX >= (1 << (ADDR_W - 2))) begin : g_bad_addr_w
      $error("axil_inputoutput_regs: ADDR_W too small for the register map");
    end
  endgenerate

  logic [NUM_OUT-1:0][DATA_W-1:0] out_regs;
  logic [NUM_IN-1:0][DATA_W-1:0]  in_regs;
  logic [NUM_IN-1:0]              in_chg;

  w_state_t          w_state, w_next;
  r_state_t          r_state, r_next;
  logic              awready_q, arready_q;
  resp_t             bresp_q, rresp_q;
  logic [DATA_W-1:0] rdata_q;

  logic [31:0]       widx, ridx;
  logic              w_fire, r_fire;
  logic              w_out_hit, w_stat_hit, w_mask_hit;
  logic [DATA_W-1:0] rd_data;
  resp_t             rd_resp;

  assign widx = 32'(S_AXI_AWADDR[ADDR_W-1:2]);
  assign ridx = 32'(S_AXI_ARADDR[ADDR_W-1:2]);

  // Byte offset within a word is ignored.
  logic unused_addr;
  assign unused_addr = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // ---------------------------------------------------------------- inputs
  for (genvar j = 0; j < NUM_IN; j++) begin : g_in
    axil_io_sync #(.W(DATA_W)) u_sync (
      .clk   (ACLK),
      .rst_n (ARESETN),
      .d     (gpio_in[j*DATA_W +: DATA_W]),
      .q     (in_regs[j]),
      .chg   (in_chg[j])
    );
  end

  // ----------------------------------------------------------- write path
  // Ready is registered: it rises the cycle after AW and W are both seen,
  // and the transfer completes on the edge where ready meets valid.
  assign w_fire = (w_state == W_IDLE) && awready_q && S_AXI_AWVALID && S_AXI_WVALID;

  assign w_out_hit = widx < 32'(NUM_OUT);
`ifdef AXIL_INPUTOUTPUT_IRQ_EN
  assign w_stat_hit = widx == 32'(STAT_IDX);
  assign w_mask_hit = widx == 32'(MASK_IDX);
`else
  assign w_stat_hit = 1'b0;
  assign w_mask_hit = 1'b0;
`endif

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (w_fire) w_next = W_RESP;
      W_RESP:  if (S_AXI_BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      w_state   <= w_next;
      awready_q <= (w_state == W_IDLE) && !awready_q && S_AXI_AWVALID && S_AXI_WVALID;
      if (w_fire) bresp_q <= (w_out_hit || w_stat_hit || w_mask_hit) ? OKAY : SLVERR;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int k = 0; k < NUM_OUT; k++) out_regs[k] <= OUT_RST_VAL;
    end else if (w_fire) begin
      for (int k = 0; k < NUM_OUT; k++)
        if (widx == 32'(k))
          for (int b = 0; b < NB; b++)
            if (S_AXI_WSTRB[b]) out_regs[k][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign gpio_out      = out_regs;

  // ------------------------------------------------------------ interrupts
`ifdef AXIL_INPUTOUTPUT_IRQ_EN
  logic [NUM_IN-1:0] irq_status, irq_mask, w_bit_en, stat_clr;
  logic              irq_q;

  // Each status/mask bit follows the strobe of the byte lane it lives in.
  always_comb begin
    w_bit_en = '0;
    for (int j = 0; j < NUM_IN; j++) w_bit_en[j] = S_AXI_WSTRB[j/8];
  end

  assign stat_clr = (w_fire && w_stat_hit) ? (S_AXI_WDATA[NUM_IN-1:0] & w_bit_en) : '0;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      irq_status <= '0;
      irq_mask   <= '0;
      irq_q      <= 1'b0;
    end else begin
      // OR-ing the change term last lets a new event beat a same-cycle clear.
      irq_status <= (irq_status & ~stat_clr) | in_chg;
      if (w_fire && w_mask_hit)
        irq_mask <= (irq_mask & ~w_bit_en) | (S_AXI_WDATA[NUM_IN-1:0] & w_bit_en);
      irq_q <= |(irq_status & irq_mask);
    end
  end

  assign irq = irq_q;
`else
  logic unused_chg;
  assign unused_chg = ^in_chg;
`endif

  // ------------------------------------------------------------ read path
  always_comb begin
    rd_data = '0;
    rd_resp = SLVERR;
    for (int k = 0; k < NUM_OUT; k++)
      if (ridx == 32'(k)) begin
        rd_data = out_regs[k];
        rd_resp = OKAY;
      end
    for (int j = 0; j < NUM_IN; j++)
      if (ridx == 32'(NUM_OUT + j)) begin
        rd_data = in_regs[j];
        rd_resp = OKAY;
      end
`ifdef AXIL_INPUTOUTPUT_IRQ_EN
    if (ridx == 32'(STAT_IDX)) begin
      rd_data = DATA_W'(irq_status);
      rd_resp = OKAY;
    end
    if (ridx == 32'(MASK_IDX)) begin
      rd_data = DATA_W'(irq_mask);
      rd_resp = OKAY;
    end
`endif
  end

  assign r_fire = (r_state == R_IDLE) && arready_q && S_AXI_ARVALID;

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (r_fire) r_next = R_DATA;
      R_DATA:  if (S_AXI_RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Data is captured on the handshake edge, so a write landing on the same
  // edge is not visible to this read.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      r_state   <= r_next;
      arready_q <= (r_state == R_IDLE) && !arready_q && S_AXI_ARVALID;
      if (r_fire) begin
        rdata_q <= rd_data;
        rresp_q <= rd_resp;
      end
    end
  end

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axil_inputoutput_regs.sv
// Directed bench for axil_inputoutput_regs at default parameters.
module tb_axil_inputoutput_regs;

  localparam int DW = 32;
  localparam int NO = 4;
  localparam int NI = 2;
  localparam int AW = 8;

  logic             ACLK = 1'b0;
  logic             ARESETN;
  logic [AW-1:0]    awaddr, araddr;
  logic             awvalid, awready, wvalid, wready, bvalid, bready;
  logic             arvalid, arready, rvalid, rready;
  logic [DW-1:0]    wdata, rdata;
  logic [DW/8-1:0]  wstrb;
  logic [1:0]       bresp, rresp;
  logic [NO*DW-1:0] gpio_out;
  logic [NI*DW-1:0] gpio_in;
`ifdef AXIL_INPUTOUTPUT_IRQ_EN
  logic             irq;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 ACLK = ~ACLK;

  axil_inputoutput_regs dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .gpio_out      (gpio_out),
`ifdef AXIL_INPUTOUTPUT_IRQ_EN
    .irq           (irq),
`endif
    .gpio_in       (gpio_in)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives AW and W together, optionally stalls BREADY for 'hold' cycles.
  task automatic axi_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW/8-1:0] s, input logic [1:0] exp_resp, input int hold);
    int n;
    @(negedge ACLK);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge ACLK); n++; end
    check({tag, " aw/w timeout"}, 64'(n < 20), 64'd1);
    @(negedge ACLK);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge ACLK); n++; end
    check({tag, " bvalid"}, 64'(bvalid), 64'd1);
    check({tag, " bresp"}, 64'(bresp), 64'(exp_resp));
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      check({tag, " bvalid hold"}, 64'(bvalid), 64'd1);
      check({tag, " bresp hold"}, 64'(bresp), 64'(exp_resp));
    end
    bready = 1'b1;
    @(negedge ACLK);
    bready = 1'b0;
    check({tag, " bvalid drop"}, 64'(bvalid), 64'd0);
  endtask

  task automatic axi_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp_data,
                          input logic [1:0] exp_resp, input int hold);
    int n;
    @(negedge ACLK);
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 20) begin @(negedge ACLK); n++; end
    check({tag, " ar timeout"}, 64'(n < 20), 64'd1);
    @(negedge ACLK);
    arvalid = 1'b0;
    check({tag, " rvalid"}, 64'(rvalid), 64'd1);
    check({tag, " rdata"}, 64'(rdata), 64'(exp_data));
    check({tag, " rresp"}, 64'(rresp), 64'(exp_resp));
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      check({tag, " rvalid hold"}, 64'(rvalid), 64'd1);
      check({tag, " rdata hold"}, 64'(rdata), 64'(exp_data));
      check({tag, " rresp hold"}, 64'(rresp), 64'(exp_resp));
    end
    rready = 1'b1;
    @(negedge ACLK);
    rready = 1'b0;
    check({tag, " rvalid drop"}, 64'(rvalid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    ARESETN = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0; gpio_in = '0;

    // Reset state
    repeat (3) @(negedge ACLK);
    check("rst awready", 64'(awready), 64'd0);
    check("rst wready", 64'(wready), 64'd0);
    check("rst bvalid", 64'(bvalid), 64'd0);
    check("rst bresp", 64'(bresp), 64'd0);
    check("rst arready", 64'(arready), 64'd0);
    check("rst rvalid", 64'(rvalid), 64'd0);
    check("rst rdata", 64'(rdata), 64'd0);
    check("rst rresp", 64'(rresp), 64'd0);
    for (int k = 0; k < NO; k++) check($sformatf("rst gpio_out%0d", k), 64'(gpio_out[k*DW +: DW]), 64'd0);
`ifdef AXIL_INPUTOUTPUT_IRQ_EN
    check("rst irq", 64'(irq), 64'd0);
`endif
    ARESETN = 1'b1;

    // Output registers: full-word writes and read-back
    for (int k = 0; k < NO; k++)
      axi_write($sformatf("wr%0d", k), AW'(4*k), DW'(k+1), 4'hF, 2'b00, 0);
    for (int k = 0; k < NO; k++) begin
      axi_read($sformatf("rd%0d", k), AW'(4*k), DW'(k+1), 2'b00, 0);
      check($sformatf("gpio_out%0d", k), 64'(gpio_out[k*DW +: DW]), 64'(k+1));
    end

    // Byte strobes
    axi_write("wr full", 8'h00, 32'hAABBCCDD, 4'hF, 2'b00, 0);
    axi_write("wr strb", 8'h00, 32'h11223344, 4'b0101, 2'b00, 0);
    axi_read("rd strb", 8'h00, 32'hAA22CC44, 2'b00, 0);
    check("gpio_out0 strb", 64'(gpio_out[31:0]), 64'hAA22CC44);

    // Input registers, read-only
    gpio_in = {32'hDEADBEEF, 32'h00000000};
    repeat (3) @(negedge ACLK);
    axi_read("rd in1", 8'h14, 32'hDEADBEEF, 2'b00, 0);
    axi_read("rd in0", 8'h10, 32'h00000000, 2'b00, 0);
    axi_write("wr in1", 8'h14, 32'h00000005, 4'hF, 2'b10, 0);
    axi_read("rd in1 again", 8'h14, 32'hDEADBEEF, 2'b00, 0);

    // Unmapped accesses with stalled response channels
    axi_read("rd unmapped", 8'h40, 32'h0, 2'b10, 5);
    axi_write("wr unmapped", 8'h40, 32'hFFFFFFFF, 4'hF, 2'b10, 5);
    check("gpio_out0 after unmapped", 64'(gpio_out[31:0]), 64'hAA22CC44);
    check("gpio_out3 after unmapped", 64'(gpio_out[127:96]), 64'h4);

`ifdef AXIL_INPUTOUTPUT_IRQ_EN
    // Clear the status left by the gpio_in change above, then arm bit 0.
    axi_write("wr stat clr all", 8'h18, 32'h3, 4'hF, 2'b00, 0);
    axi_read("rd stat clear", 8'h18, 32'h0, 2'b00, 0);
    axi_write("wr mask", 8'h1C, 32'h1, 4'hF, 2'b00, 0);
    axi_read("rd mask", 8'h1C, 32'h1, 2'b00, 0);
    check("irq idle", 64'(irq), 64'd0);
    gpio_in[0] = ~gpio_in[0];
    n = 0;
    while (!irq && n < 10) begin @(negedge ACLK); n++; end
    check("irq latency", 64'(n <= 4), 64'd1);
    axi_read("rd stat set", 8'h18, 32'h1, 2'b00, 0);
    axi_write("wr stat clr", 8'h18, 32'h1, 4'hF, 2'b00, 0);
    check("irq cleared", 64'(irq), 64'd0);
    // Toggle so the change is detected on the same edge the clear lands.
    gpio_in[0] = ~gpio_in[0];
    axi_write("wr stat clr race", 8'h18, 32'h1, 4'hF, 2'b00, 0);
    axi_read("rd stat set wins", 8'h18, 32'h1, 2'b00, 0);
    check("irq after race", 64'(irq), 64'd1);
`else
    axi_write("wr irq stat", 8'h18, 32'h1, 4'hF, 2'b10, 0);
    axi_read("rd irq stat", 8'h18, 32'h0, 2'b10, 0);
    axi_write("wr irq mask", 8'h1C, 32'h1, 4'hF, 2'b10, 0);
    axi_read("rd irq mask", 8'h1C, 32'h0, 2'b10, 0);
`endif

    // Reset while the write response is pending
    @(negedge ACLK);
    awaddr = 8'h00; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!awready && n < 20) begin @(negedge ACLK); n++; end
    check("mid rst aw timeout", 64'(n < 20), 64'd1);
    @(negedge ACLK);
    awvalid = 1'b0; wvalid = 1'b0;
    check("mid rst bvalid pending", 64'(bvalid), 64'd1);
    ARESETN = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    check("mid rst bvalid", 64'(bvalid), 64'd0);
    for (int k = 0; k < NO; k++) check($sformatf("mid rst gpio_out%0d", k), 64'(gpio_out[k*DW +: DW]), 64'd0);
    bready = 1'b1;
    repeat (3) @(negedge ACLK);
    check("mid rst no late bvalid", 64'(bvalid), 64'd0);
    bready = 1'b0;
    for (int k = 0; k < NO; k++)
      axi_read($sformatf("rd after rst%0d", k), AW'(4*k), 32'h0, 2'b00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
